// File: rtl/result_uart_tx.sv
// Serialises each newly observed 32-bit result word as four 8N1 UART bytes, LSB byte first.
// New values that arrive mid-word wait in a one-deep pending slot. Older pending values are dropped.
module result_uart_tx #(
    parameter int unsigned word_width   = 32,
    parameter int unsigned clks_per_bit = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [word_width-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           word_cnt,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] BaudMax = 16'(clks_per_bit - 1);

    state_e                state_q, state_d;
    logic [word_width-1:0] last_val_q, last_val_d;
    logic [word_width-1:0] buf_q, buf_d;
    logic [word_width-1:0] pend_val_q, pend_val_d;
    logic                  pend_q, pend_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [1:0]            byte_q, byte_d;
    logic                  tx_q, tx_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic new_val, bit_done, word_done, consume, direct, pend_accept;

    assign new_val     = (data_in != last_val_q);
    assign bit_done    = (state_q != StIdle) && (baud_q == BaudMax);
    assign word_done   = (state_q == StStop) && bit_done && (byte_q == 2'd3);
    assign consume     = word_done && pend_q;
    // A value landing as the last stop bit ends with nothing pending starts immediately.
    assign direct      = new_val && ((state_q == StIdle) || (word_done && !pend_q));
    assign pend_accept = new_val && !direct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_val_q <= '0;
            buf_q      <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            buf_q      <= buf_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = new_val ? data_in : last_val_q;
        buf_d      = buf_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_cnt_d = word_done ? word_cnt_q + 16'd1 : word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == StIdle || bit_done) baud_d = '0;
        else                               baud_d = baud_q + 16'd1;

        unique case (state_q)
            StIdle: begin
                if (direct) begin
                    state_d = StStart;
                    buf_d   = data_in;
                    byte_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    bit_d = '0;
                    if (byte_q != 2'd3) begin
                        state_d = StStart;
                        byte_d  = byte_q + 2'd1;
                    end else if (pend_q) begin
                        state_d = StStart;
                        buf_d   = pend_val_q;
                        byte_d  = '0;
                    end else if (direct) begin
                        state_d = StStart;
                        buf_d   = data_in;
                        byte_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (consume) pend_d = 1'b0;
        if (pend_accept) begin
            pend_d     = 1'b1;
            pend_val_d = data_in;
            // Refilling the slot as it is being consumed is not a drop.
            if (pend_q && !consume && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = buf_d[{byte_d, bit_d}];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: decodes the tx line sample by sample at 4 clocks per bit.
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int NBITS = 40;
    localparam int NS    = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        tx, busy;
    logic [15:0] word_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] exp_words;
    } vec_t;

    vec_t vecs [4];

    result_uart_tx #(
        .word_width  (32),
        .clks_per_bit(CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .word_cnt(word_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // First sample is taken after the next rising edge; wait_cyc=0 means tx was low there.
    task automatic recv_word(output logic [31:0] w, output int wait_cyc, output int frame_err,
                             output logic busy_last);
        logic s [NS];
        logic v;
        int   pos;
        w = '0; wait_cyc = 0; frame_err = 0; busy_last = 1'b0;
        tick();
        while (tx !== 1'b0 && wait_cyc < 400) begin
            wait_cyc++;
            tick();
        end
        if (tx !== 1'b0) begin
            wait_cyc = -1;
            return;
        end
        s[0] = tx;
        for (int k = 1; k < NS; k++) begin
            tick();
            s[k] = tx;
        end
        busy_last = busy;
        for (int b = 0; b < NBITS; b++) begin
            v = s[b*CPB];
            for (int k = 1; k < CPB; k++) if (s[b*CPB+k] !== v) frame_err++;
            pos = b % 10;
            if (pos == 0) begin
                if (v !== 1'b0) frame_err++;
            end else if (pos == 9) begin
                if (v !== 1'b1) frame_err++;
            end else begin
                w[(b/10)*8 + pos - 1] = v;
            end
        end
    endtask

    task automatic recv_expect(input string name, input logic [31:0] exp, input int exp_wait);
        logic [31:0] w;
        int          wc, fe;
        logic        bl;
        recv_word(w, wc, fe, bl);
        chk({name, "_start_delay"}, wc, exp_wait);
        chk({name, "_data"}, w, exp);
        chk({name, "_framing"}, fe, 0);
        chk({name, "_busy_last_cycle"}, bl, 1'b1);
    endtask

    task automatic expect_idle_after(input string name);
        tick();
        chk({name, "_busy_after"}, busy, 1'b0);
        chk({name, "_tx_after"}, tx, 1'b1);
    endtask

    initial begin
        int viol;
        int guard;

        vecs[0] = '{data: 32'h44332211, exp_words: 16'd1};
        vecs[1] = '{data: 32'hDEADBEEF, exp_words: 16'd2};
        vecs[2] = '{data: 32'h00000001, exp_words: 16'd3};
        vecs[3] = '{data: 32'h80000000, exp_words: 16'd4};

        // Reset values
        repeat (3) tick();
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_word_cnt", word_cnt, 16'd0);
        chk("reset_drop_cnt", drop_cnt, 8'd0);
        rst_n = 1'b1;

        // Zero after reset must not transmit
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("zero_hold_activity", viol, 0);
        chk("zero_hold_word_cnt", word_cnt, 16'd0);

        // Table of single words
        for (int i = 0; i < 4; i++) begin
            data_in = vecs[i].data;
            recv_expect($sformatf("vec%0d", i), vecs[i].data, 0);
            expect_idle_after($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_word_cnt", i), word_cnt, vecs[i].exp_words);
        end

        // Unchanged input is never resent
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("const_hold_activity", viol, 0);
        chk("const_hold_word_cnt", word_cnt, 16'd4);

        // Pending word follows with no gap
        data_in = 32'h000000A5;
        fork
            recv_expect("pend_first", 32'h000000A5, 0);
            begin
                repeat (20) @(posedge clk);
                #2 data_in = 32'h0000005A;
            end
        join
        recv_expect("pend_second", 32'h0000005A, 0);
        expect_idle_after("pend_second");
        chk("pend_drop_cnt", drop_cnt, 8'd0);
        chk("pend_word_cnt", word_cnt, 16'd6);

        // Overwritten pending values are dropped
        data_in = 32'hCAFEF00D;
        fork
            recv_expect("drop_first", 32'hCAFEF00D, 0);
            begin
                repeat (10) @(posedge clk);
                #2 data_in = 32'd1;
                repeat (20) @(posedge clk);
                #2 data_in = 32'd2;
                repeat (20) @(posedge clk);
                #2 data_in = 32'd3;
            end
        join
        recv_expect("drop_last", 32'd3, 0);
        expect_idle_after("drop_last");
        chk("drop_drop_cnt", drop_cnt, 8'd2);
        chk("drop_word_cnt", word_cnt, 16'd8);

        // New pending value on the edge the old one is consumed: no drop
        data_in = 32'h0A0A0A0A;
        fork
            recv_expect("edge_a", 32'h0A0A0A0A, 0);
            begin
                repeat (20) @(posedge clk);
                #2 data_in = 32'h0B0B0B0B;
                repeat (140) @(posedge clk);
                #2 data_in = 32'h0C0C0C0C;
            end
        join
        recv_expect("edge_b", 32'h0B0B0B0B, 0);
        recv_expect("edge_c", 32'h0C0C0C0C, 0);
        expect_idle_after("edge_c");
        chk("edge_drop_cnt", drop_cnt, 8'd2);
        chk("edge_word_cnt", word_cnt, 16'd11);

        // New value exactly as the last stop bit ends with nothing pending
        data_in = 32'h0D0D0D0D;
        fork
            recv_expect("stop_d", 32'h0D0D0D0D, 0);
            begin
                repeat (160) @(posedge clk);
                #2 data_in = 32'h0E0E0E0E;
            end
        join
        recv_expect("stop_e", 32'h0E0E0E0E, 0);
        expect_idle_after("stop_e");
        chk("stop_word_cnt", word_cnt, 16'd13);

        // drop_cnt saturates
        for (int i = 0; i < 300; i++) begin
            data_in = 32'h10000000 + i;
            tick();
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("sat_flush_timeout", (guard < 2000), 1'b1);
        chk("sat_drop_cnt", drop_cnt, 8'd255);

        // Reset mid-frame aborts, then the word is resent in full
        data_in = 32'h0F0F1234;
        repeat (50) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        tick();
        chk("midrst_word_cnt", word_cnt, 16'd0);
        chk("midrst_drop_cnt", drop_cnt, 8'd0);
        rst_n = 1'b1;
        recv_expect("midrst_resend", 32'h0F0F1234, 0);
        expect_idle_after("midrst_resend");
        chk("midrst_resend_word_cnt", word_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
- REQ-001: Parameter word_width, default 32: width of data_in; fixed at 32 for this block (4 bytes).
- REQ-002: Parameter clks_per_bit, default 16: clock cycles per UART bit; legal range 2..65535.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset; asynchronous, active-low.
- REQ-005: data_in  input  32  result word driven by the processor core's final_data output.
- REQ-006: tx  output  1  UART serial line, 8N1, idle high.
- REQ-007: busy  output  1  high while a word is being serialized.
- REQ-008: word_cnt  output  16  count of fully transmitted words.
- REQ-009: drop_cnt  output  8  count of accepted values overwritten before transmission.

Function
- REQ-010: On every clock edge, data_in SHALL be compared against last_val, the most recently accepted value; inequality means a new value is present.
- REQ-011: Accepting a value SHALL update last_val to data_in in the same edge.
- REQ-012: If the FSM is in IDLE and a new value is present, the block SHALL load it into the transmit buffer and enter START.
- REQ-013: tx SHALL be registered; tx SHALL be 0 in the cycle immediately after the accepting edge.
- REQ-014: FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-015: Transitions SHALL be IDLE->START on acceptance, START->DATA after clks_per_bit cycles, and DATA->STOP after 8 bits.
- REQ-016: From STOP after clks_per_bit cycles, the FSM SHALL go to START with the next byte while bytes remain, otherwise to START with the pending word if pend=1, otherwise to IDLE.
- REQ-017: Each bit SHALL last exactly clks_per_bit cycles, timed by a baud counter that reloads at every bit boundary.
- REQ-018: Bytes SHALL be sent in the order data[7:0], [15:8], [23:16], [31:24]; bits within each byte SHALL be sent LSB first.
- REQ-019: One word SHALL occupy exactly 40*clks_per_bit cycles on tx.
- REQ-020: Back-to-back words (pending case) SHALL have no idle cycle between the stop bit and the next start bit.
- REQ-021: While not IDLE, a new value SHALL be accepted into a one-deep pending register and pend SHALL be set.
- REQ-022: If pend is already set when a new value is accepted, the pending register SHALL be overwritten and drop_cnt SHALL increment.
- REQ-023: drop_cnt SHALL saturate at 255.
- REQ-024: Pending-register acceptance on the same edge that the FSM consumes the pending word SHALL be treated as a new pending value: pend stays 1 and drop_cnt does not increment.
- REQ-025: A new value arriving on the edge where STOP completes with pend=0 SHALL be accepted as if the FSM were IDLE, with no idle cycle.
- REQ-026: busy SHALL be 1 in every state except IDLE.
- REQ-027: word_cnt SHALL increment on the final STOP-bit completion of each word.
- REQ-028: word_cnt SHALL wrap from 65535 to 0.
- REQ-029: A value equal to last_val SHALL never be transmitted again (no repeat for an unchanged input).

Reset
- REQ-030: While rst_n=0: tx=1, busy=0, FSM=IDLE, last_val=0, pend=0, word_cnt=0, drop_cnt=0, baud and bit counters=0.
- REQ-031: Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with tx forced to 1.
- REQ-032: After reset release, data_in=0 SHALL NOT trigger a transmission; any nonzero data_in SHALL trigger one.

Verification (clks_per_bit=4)
- REQ-033: Reset, hold data_in=0 for 200 cycles -> tx stays 1, busy=0, word_cnt=0.
- REQ-034: data_in=0x44332211 -> frames 0x11,0x22,0x33,0x44, each start 0 + LSB-first bits + stop 1, 160 cycles total; busy drops after that; word_cnt=1.
- REQ-035: data_in=0xA5 then 0x5A at cycle 20 -> 0x000000A5 sent, then 0x0000005A starts with no idle gap; drop_cnt=0; word_cnt=2.
- REQ-036: During one frame, change data_in to 1, 2, 3 -> only 3 sent after the first word; drop_cnt=2.
- REQ-037: Assert rst_n=0 at cycle 50 of a frame -> tx=1 and busy=0 immediately; after release with the same nonzero data_in, the word is retransmitted in full.
- REQ-038: Hold 0x12345678 constant through a completed word -> no second transmission; word_cnt stays 1.
